// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle main controller
package mc_defs;

    // Controller states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Decoded instruction classes; C_ILL marks anything outside the legal set
    typedef enum logic [3:0] {
        C_ILL   = 4'd0,
        C_ADDU  = 4'd1,
        C_SUBU  = 4'd2,
        C_SLL   = 4'd3,
        C_SRL   = 4'd4,
        C_ORI   = 4'd5,
        C_LUI   = 4'd6,
        C_ADDIU = 4'd7,
        C_LW    = 4'd8,
        C_SW    = 4'd9,
        C_BEQ   = 4'd10,
        C_J     = 4'd11,
        C_JAL   = 4'd12
    } iclass_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;

    // ALU operation select
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;

    // Immediate extender mode
    localparam logic [1:0] EXT_SHAMT = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b10;
    localparam logic [1:0] EXT_SIGN  = 2'b11;

    // Next-PC select
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Register-file write address select
    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    // Register-file write data select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - opcode/funct to instruction class and EXEC/WB control fields
module mc_decode
    import mc_defs::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output iclass_t    o_cls,
    output logic       o_legal,
    output logic [2:0] o_alu_op,
    output logic       o_alusrc,
    output logic [1:0] o_extop,
    output logic [1:0] o_regdst,
    output logic [1:0] o_wb_sel
);

    // Classify the instruction; anything not explicitly listed is illegal
    always_comb begin
        o_cls = C_ILL;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADDU: o_cls = C_ADDU;
                    FN_SUBU: o_cls = C_SUBU;
                    FN_SLL:  o_cls = C_SLL;
                    FN_SRL:  o_cls = C_SRL;
                    default: o_cls = C_ILL;
                endcase
            end
            OP_ORI:   o_cls = C_ORI;
            OP_LUI:   o_cls = C_LUI;
            OP_ADDIU: o_cls = C_ADDIU;
            OP_LW:    o_cls = C_LW;
            OP_SW:    o_cls = C_SW;
            OP_BEQ:   o_cls = C_BEQ;
            OP_J:     o_cls = C_J;
            OP_JAL:   o_cls = C_JAL;
            default:  o_cls = C_ILL;
        endcase
    end

    assign o_legal = (o_cls != C_ILL);

    // Datapath settings used in EXEC (ALU/extender) and WB (destination/source)
    always_comb begin
        o_alu_op = ALU_ADD;
        o_alusrc = 1'b0;
        o_extop  = EXT_SHAMT;
        o_regdst = RD_RT;
        o_wb_sel = WB_ALU;
        case (o_cls)
            C_ADDU: begin
                o_alu_op = ALU_ADD;
                o_regdst = RD_RD;
            end
            C_SUBU: begin
                o_alu_op = ALU_SUB;
                o_regdst = RD_RD;
            end
            C_SLL: begin
                o_alu_op = ALU_SLL;
                o_alusrc = 1'b1;
                o_extop  = EXT_SHAMT;
                o_regdst = RD_RD;
            end
            C_SRL: begin
                o_alu_op = ALU_SRL;
                o_alusrc = 1'b1;
                o_extop  = EXT_SHAMT;
                o_regdst = RD_RD;
            end
            C_ORI: begin
                o_alu_op = ALU_OR;
                o_alusrc = 1'b1;
                o_extop  = EXT_ZERO;
            end
            C_LUI: begin
                o_alu_op = ALU_LUI;
                o_alusrc = 1'b1;
                o_extop  = EXT_ZERO;
            end
            C_ADDIU, C_SW: begin
                o_alu_op = ALU_ADD;
                o_alusrc = 1'b1;
                o_extop  = EXT_SIGN;
            end
            C_LW: begin
                o_alu_op = ALU_ADD;
                o_alusrc = 1'b1;
                o_extop  = EXT_SIGN;
                o_wb_sel = WB_MEM;
            end
            C_BEQ: begin
                o_alu_op = ALU_SUB;
                o_extop  = EXT_SIGN;
            end
            default: begin
                o_alu_op = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS-subset main controller FSM with bus timeout
module mc_ctrl
    import mc_defs::*;
#(
    parameter int TIMEOUT         = 255,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       reg_we,
    output logic [1:0] regdst,
    output logic [1:0] wb_sel,
    output logic       alusrc,
    output logic [2:0] alu_op,
    output logic [1:0] extop,
    output logic       illegal,
    output logic       bus_err,
    output logic       halted
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;

    iclass_t     w_cls;
    logic        w_legal;
    logic [2:0]  w_alu_op;
    logic        w_alusrc;
    logic [1:0]  w_extop;
    logic [1:0]  w_regdst;
    logic [1:0]  w_wb_sel;
    logic        w_waiting;
    logic        w_tmo;

    mc_decode u_decode (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_cls    (w_cls),
        .o_legal  (w_legal),
        .o_alu_op (w_alu_op),
        .o_alusrc (w_alusrc),
        .o_extop  (w_extop),
        .o_regdst (w_regdst),
        .o_wb_sel (w_wb_sel)
    );

    // A request is outstanding in FETCH/MEM whenever the memory has not acked
    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ack;
    // The limit-th unacknowledged cycle raises the error; an ack that cycle wins
    assign w_tmo     = (TIMEOUT > 0) && w_waiting && (r_cnt == 16'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Wait-cycle counter: counts unacked request cycles, clears otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_waiting) begin
            r_cnt <= r_cnt + 16'd1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Next-state and Moore-per-state output decode
    always_comb begin
        w_next  = r_state;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        iord    = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = PC_PLUS4;
        reg_we  = 1'b0;
        regdst  = RD_RT;
        wb_sel  = WB_ALU;
        alusrc  = 1'b0;
        alu_op  = ALU_ADD;
        extop   = EXT_SHAMT;
        illegal = 1'b0;
        bus_err = 1'b0;
        halted  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_sel = PC_PLUS4;
                    w_next = S_DECODE;
                end else if (w_tmo) begin
                    bus_err = 1'b1;
                    w_next  = S_HALT;
                end
            end
            S_DECODE: begin
                if (!w_legal) begin
                    illegal = 1'b1;
                    w_next  = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                end else if (w_cls == C_J || w_cls == C_JAL) begin
                    pc_we  = 1'b1;
                    pc_sel = PC_JUMP;
                    if (w_cls == C_JAL) begin
                        // PC already holds PC+4 after FETCH, so it is the link value
                        reg_we = 1'b1;
                        regdst = RD_RA;
                        wb_sel = WB_PC4;
                    end
                    w_next = S_FETCH;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op = w_alu_op;
                alusrc = w_alusrc;
                extop  = w_extop;
                if (w_cls == C_BEQ) begin
                    pc_we  = zero;
                    pc_sel = PC_BRANCH;
                    w_next = S_FETCH;
                end else if (w_cls == C_LW || w_cls == C_SW) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (w_cls == C_SW);
                if (mem_ack) begin
                    w_next = (w_cls == C_SW) ? S_FETCH : S_WB;
                end else if (w_tmo) begin
                    bus_err = 1'b1;
                    w_next  = S_HALT;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                regdst = w_regdst;
                wb_sel = w_wb_sel;
                w_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard bench for mc_ctrl with two illegal-handling variants
module tb_mc_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       reg_we;
        logic [1:0] regdst;
        logic [1:0] wb_sel;
        logic       alusrc;
        logic [2:0] alu_op;
        logic [1:0] extop;
        logic       illegal;
        logic       bus_err;
        logic       halted;
    } out_t;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ack;

    logic       mem_req0, mem_we0, iord0, ir_we0, pc_we0, reg_we0, alusrc0, illegal0, bus_err0, halted0;
    logic [1:0] pc_sel0, regdst0, wb_sel0, extop0;
    logic [2:0] alu_op0;
    logic       mem_req1, mem_we1, iord1, ir_we1, pc_we1, reg_we1, alusrc1, illegal1, bus_err1, halted1;
    logic [1:0] pc_sel1, regdst1, wb_sel1, extop1;
    logic [2:0] alu_op1;

    out_t a0, a1;
    out_t q0[$];
    out_t q1[$];
    string qt[$];
    out_t m_e0, m_e1;
    string m_tag;
    int checks = 0;
    int failures = 0;
    out_t Z;

    mc_ctrl #(.TIMEOUT(4), .HALT_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req0), .mem_we(mem_we0), .iord(iord0), .ir_we(ir_we0), .pc_we(pc_we0),
        .pc_sel(pc_sel0), .reg_we(reg_we0), .regdst(regdst0), .wb_sel(wb_sel0), .alusrc(alusrc0),
        .alu_op(alu_op0), .extop(extop0), .illegal(illegal0), .bus_err(bus_err0), .halted(halted0)
    );

    mc_ctrl #(.TIMEOUT(4), .HALT_ON_ILLEGAL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req1), .mem_we(mem_we1), .iord(iord1), .ir_we(ir_we1), .pc_we(pc_we1),
        .pc_sel(pc_sel1), .reg_we(reg_we1), .regdst(regdst1), .wb_sel(wb_sel1), .alusrc(alusrc1),
        .alu_op(alu_op1), .extop(extop1), .illegal(illegal1), .bus_err(bus_err1), .halted(halted1)
    );

    assign a0 = {mem_req0, mem_we0, iord0, ir_we0, pc_we0, pc_sel0, reg_we0, regdst0, wb_sel0,
                 alusrc0, alu_op0, extop0, illegal0, bus_err0, halted0};
    assign a1 = {mem_req1, mem_we1, iord1, ir_we1, pc_we1, pc_sel1, reg_we1, regdst1, wb_sel1,
                 alusrc1, alu_op1, extop1, illegal1, bus_err1, halted1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: each cycle with a pending expectation, compare both controllers
    always @(negedge clk) begin
        if (q0.size() > 0) begin
            m_e0  = q0.pop_front();
            m_e1  = q1.pop_front();
            m_tag = qt.pop_front();
            checks++;
            if (a0 !== m_e0) begin
                failures++;
                $display("FAIL %s dut0 got=%b required=%b", m_tag, a0, m_e0);
            end
            checks++;
            if (a1 !== m_e1) begin
                failures++;
                $display("FAIL %s dut1 got=%b required=%b", m_tag, a1, m_e1);
            end
        end
    end

    function automatic out_t f_fetch(input logic ack);
        out_t e = '0;
        e.mem_req = 1'b1;
        e.ir_we   = ack;
        e.pc_we   = ack;
        return e;
    endfunction

    function automatic out_t f_exec(input logic [2:0] op, input logic src, input logic [1:0] ext);
        out_t e = '0;
        e.alu_op = op;
        e.alusrc = src;
        e.extop  = ext;
        return e;
    endfunction

    function automatic out_t f_wb(input logic [1:0] rd, input logic [1:0] ws);
        out_t e = '0;
        e.reg_we = 1'b1;
        e.regdst = rd;
        e.wb_sel = ws;
        return e;
    endfunction

    function automatic out_t f_mem(input logic we);
        out_t e = '0;
        e.mem_req = 1'b1;
        e.iord    = 1'b1;
        e.mem_we  = we;
        return e;
    endfunction

    function automatic out_t f_halt();
        out_t e = '0;
        e.halted = 1'b1;
        return e;
    endfunction

    function automatic out_t f_flag(input logic ill, input logic berr);
        out_t e = '0;
        e.illegal = ill;
        e.bus_err = berr;
        return e;
    endfunction

    task automatic step(input string tag, input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic ack, input out_t e0, input out_t e1);
        @(posedge clk);
        #1;
        rst     = r;
        opcode  = op;
        funct   = fn;
        zero    = z;
        mem_ack = ack;
        q0.push_back(e0);
        q1.push_back(e1);
        qt.push_back(tag);
    endtask

    task automatic s(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic ack, input out_t e);
        step(tag, 1'b0, op, fn, z, ack, e, e);
    endtask

    // FETCH(ack) / DECODE / EXEC / WB for register-writing ALU instructions
    task automatic run_alu(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic [2:0] alu, input logic src, input logic [1:0] ext,
                           input logic [1:0] rd);
        s({tag, "_fetch"},  op, fn, 1'b0, 1'b1, f_fetch(1'b1));
        s({tag, "_decode"}, op, fn, 1'b0, 1'b0, Z);
        s({tag, "_exec"},   op, fn, 1'b0, 1'b0, f_exec(alu, src, ext));
        s({tag, "_wb"},     op, fn, 1'b0, 1'b0, f_wb(rd, 2'b00));
    endtask

    out_t e;

    initial begin
        Z       = '0;
        rst     = 1'b1;
        opcode  = 6'h00;
        funct   = 6'h00;
        zero    = 1'b0;
        mem_ack = 1'b0;

        step("reset_a", 1'b1, 6'h00, 6'h00, 1'b0, 1'b1, Z, Z);
        step("reset_b", 1'b1, 6'h00, 6'h00, 1'b0, 1'b1, Z, Z);
        s("idle", 6'h00, 6'h00, 1'b0, 1'b1, Z);

        run_alu("addu",  6'h00, 6'h21, 3'b000, 1'b0, 2'b00, 2'b01);
        run_alu("subu",  6'h00, 6'h23, 3'b001, 1'b0, 2'b00, 2'b01);
        run_alu("sll",   6'h00, 6'h00, 3'b100, 1'b1, 2'b00, 2'b01);
        run_alu("srl",   6'h00, 6'h02, 3'b101, 1'b1, 2'b00, 2'b01);
        run_alu("ori",   6'h0d, 6'h3f, 3'b010, 1'b1, 2'b10, 2'b00);
        run_alu("lui",   6'h0f, 6'h00, 3'b011, 1'b1, 2'b10, 2'b00);
        run_alu("addiu", 6'h09, 6'h21, 3'b000, 1'b1, 2'b11, 2'b00);

        // lw: one FETCH wait, three MEM cycles with ack on the third
        s("lw_fetch_wait", 6'h23, 6'h00, 1'b0, 1'b0, f_fetch(1'b0));
        s("lw_fetch",      6'h23, 6'h00, 1'b0, 1'b1, f_fetch(1'b1));
        s("lw_decode",     6'h23, 6'h00, 1'b0, 1'b0, Z);
        s("lw_exec",       6'h23, 6'h00, 1'b0, 1'b0, f_exec(3'b000, 1'b1, 2'b11));
        s("lw_mem1",       6'h23, 6'h00, 1'b0, 1'b0, f_mem(1'b0));
        s("lw_mem2",       6'h23, 6'h00, 1'b0, 1'b0, f_mem(1'b0));
        s("lw_mem3",       6'h23, 6'h00, 1'b0, 1'b1, f_mem(1'b0));
        s("lw_wb",         6'h23, 6'h00, 1'b0, 1'b0, f_wb(2'b00, 2'b01));

        // sw: MEM acks at once and returns straight to FETCH
        s("sw_fetch",  6'h2b, 6'h00, 1'b0, 1'b1, f_fetch(1'b1));
        s("sw_decode", 6'h2b, 6'h00, 1'b0, 1'b0, Z);
        s("sw_exec",   6'h2b, 6'h00, 1'b0, 1'b0, f_exec(3'b000, 1'b1, 2'b11));
        s("sw_mem",    6'h2b, 6'h00, 1'b0, 1'b1, f_mem(1'b1));

        // beq taken then not taken
        s("beq1_fetch",  6'h04, 6'h00, 1'b1, 1'b1, f_fetch(1'b1));
        s("beq1_decode", 6'h04, 6'h00, 1'b1, 1'b0, Z);
        e = f_exec(3'b001, 1'b0, 2'b11); e.pc_we = 1'b1; e.pc_sel = 2'b01;
        s("beq1_exec",   6'h04, 6'h00, 1'b1, 1'b0, e);
        s("beq0_fetch",  6'h04, 6'h00, 1'b0, 1'b1, f_fetch(1'b1));
        s("beq0_decode", 6'h04, 6'h00, 1'b0, 1'b0, Z);
        e = f_exec(3'b001, 1'b0, 2'b11); e.pc_sel = 2'b01;
        s("beq0_exec",   6'h04, 6'h00, 1'b0, 1'b0, e);

        // j and jal resolve in DECODE
        s("j_fetch",  6'h02, 6'h00, 1'b0, 1'b1, f_fetch(1'b1));
        e = '0; e.pc_we = 1'b1; e.pc_sel = 2'b10;
        s("j_decode", 6'h02, 6'h00, 1'b0, 1'b0, e);
        s("jal_fetch", 6'h03, 6'h00, 1'b0, 1'b1, f_fetch(1'b1));
        e = '0; e.pc_we = 1'b1; e.pc_sel = 2'b10; e.reg_we = 1'b1; e.regdst = 2'b10; e.wb_sel = 2'b10;
        s("jal_decode", 6'h03, 6'h00, 1'b0, 1'b0, e);

        // Illegal opcode 3f: dut0 continues, dut1 halts
        s("ill_fetch",  6'h3f, 6'h00, 1'b0, 1'b1, f_fetch(1'b1));
        s("ill_decode", 6'h3f, 6'h00, 1'b0, 1'b0, f_flag(1'b1, 1'b0));

        // Ack on the limit cycle wins over the timeout
        step("tmo_race_w1", 1'b0, 6'h02, 6'h00, 1'b0, 1'b0, f_fetch(1'b0), f_halt());
        step("tmo_race_w2", 1'b0, 6'h02, 6'h00, 1'b0, 1'b0, f_fetch(1'b0), f_halt());
        step("tmo_race_w3", 1'b0, 6'h02, 6'h00, 1'b0, 1'b0, f_fetch(1'b0), f_halt());
        step("tmo_race_ack", 1'b0, 6'h02, 6'h00, 1'b0, 1'b1, f_fetch(1'b1), f_halt());
        e = '0; e.pc_we = 1'b1; e.pc_sel = 2'b10;
        step("tmo_race_j", 1'b0, 6'h02, 6'h00, 1'b0, 1'b0, e, f_halt());

        // No ack at all: bus_err on the fourth wait cycle, then HALT ignoring acks
        step("tmo_w1", 1'b0, 6'h00, 6'h21, 1'b0, 1'b0, f_fetch(1'b0), f_halt());
        step("tmo_w2", 1'b0, 6'h00, 6'h21, 1'b0, 1'b0, f_fetch(1'b0), f_halt());
        step("tmo_w3", 1'b0, 6'h00, 6'h21, 1'b0, 1'b0, f_fetch(1'b0), f_halt());
        e = f_fetch(1'b0); e.bus_err = 1'b1;
        step("tmo_w4", 1'b0, 6'h00, 6'h21, 1'b0, 1'b0, e, f_halt());
        s("halt_a", 6'h00, 6'h21, 1'b0, 1'b1, f_halt());
        s("halt_b", 6'h00, 6'h21, 1'b0, 1'b1, f_halt());

        // Reset leaves HALT, then reset mid-FETCH drops mem_req immediately
        step("rst_halt", 1'b1, 6'h00, 6'h21, 1'b0, 1'b0, Z, Z);
        s("rst_idle",    6'h00, 6'h21, 1'b0, 1'b0, Z);
        s("rst_fetch1",  6'h00, 6'h21, 1'b0, 1'b0, f_fetch(1'b0));
        s("rst_fetch2",  6'h00, 6'h21, 1'b0, 1'b0, f_fetch(1'b0));
        step("rst_mid", 1'b1, 6'h00, 6'h21, 1'b0, 1'b0, Z, Z);
        s("rst_idle2",   6'h00, 6'h21, 1'b0, 1'b0, Z);
        s("rst_fetch3",  6'h00, 6'h21, 1'b0, 1'b0, f_fetch(1'b0));

        // Illegal funct under opcode 00
        s("illfn_fetch",  6'h00, 6'h01, 1'b0, 1'b1, f_fetch(1'b1));
        s("illfn_decode", 6'h00, 6'h01, 1'b0, 1'b0, f_flag(1'b1, 1'b0));
        step("illfn_next", 1'b0, 6'h00, 6'h01, 1'b0, 1'b0, f_fetch(1'b0), f_halt());

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q0.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d required=0", q0.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multicycle main controller for the MIPS-subset CPU. It sequences fetch/decode/execute/memory/writeback over the existing datapath: PC, IR, register file, immediate extender, ALU, and a shared instruction/data memory. It drives every datapath enable and mux select, including the extender's extop. It also owns the memory request/acknowledge handshake and the illegal-instruction and bus-timeout detection.

Parameters:
TIMEOUT, 255, max cycles waiting for mem_ack before bus_err; 0 disables the timeout
HALT_ON_ILLEGAL, 0, 1 = enter HALT on an illegal instruction; 0 = treat it as NOP and continue

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag (valid in EXEC)
mem_ack  in  1  memory completes the current request this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe, qualified by mem_req
iord  out  1  memory address select: 0 = PC, 1 = ALU result register
ir_we  out  1  IR load
pc_we  out  1  PC load
pc_sel  out  2  next PC: 00 = PC+4, 01 = branch target, 10 = jump target
reg_we  out  1  register-file write
regdst  out  2  write register: 00 = rt, 01 = rd, 10 = r31
wb_sel  out  2  write data: 00 = ALU, 01 = memory, 10 = PC+4
alusrc  out  1  ALU B operand: 0 = rt, 1 = extender output
alu_op  out  3  000 = add, 001 = sub, 010 = or, 011 = lui, 100 = sll, 101 = srl
extop  out  2  00 = shamt [10:6] zero-extend, 10 = imm16 zero-extend, 11 = imm16 sign-extend
illegal  out  1  one-cycle pulse on an undecodable instruction
bus_err  out  1  one-cycle pulse on mem_ack timeout
halted  out  1  high while in HALT

Behaviour:
- Single clock domain, clk. rst is asynchronous and active-high.
- On rst: state = IDLE, timeout counter = 0. All outputs are 0 while rst is high and while in IDLE.
- IDLE -> FETCH unconditionally on the first clock after reset release.
- Outputs are decoded combinationally from state, opcode and funct (Moore-style per state). Any signal not listed for a state is 0.
- FETCH: mem_req = 1, iord = 0.
  - On mem_ack: ir_we = 1, pc_we = 1, pc_sel = 00; go to DECODE.
  - Without mem_ack: stay in FETCH.
- DECODE:
  - j: pc_we = 1, pc_sel = 10; go to FETCH.
  - jal: as j, plus reg_we = 1, regdst = 10, wb_sel = 10. PC+4 is taken from the already-incremented PC.
  - Legal otherwise: go to EXEC.
  - Illegal: pulse illegal; go to HALT if HALT_ON_ILLEGAL, else FETCH.
- EXEC settings by instruction:
  - addu: alu_op = 000, alusrc = 0.
  - subu: alu_op = 001, alusrc = 0.
  - sll: alu_op = 100, alusrc = 1, extop = 00.
  - srl: alu_op = 101, alusrc = 1, extop = 00.
  - ori: alu_op = 010, alusrc = 1, extop = 10.
  - lui: alu_op = 011, alusrc = 1, extop = 10.
  - addiu, lw, sw: alu_op = 000, alusrc = 1, extop = 11.
  - beq: alu_op = 001, alusrc = 0, extop = 11. pc_we = zero, pc_sel = 01; go to FETCH.
- EXEC next state: lw/sw go to MEM; all other non-branch instructions go to WB.
- MEM: mem_req = 1, iord = 1, mem_we = 1 for sw.
  - On mem_ack: lw goes to WB, sw goes to FETCH.
- WB: reg_we = 1.
  - R-type: regdst = 01, wb_sel = 00.
  - ori, lui, addiu: regdst = 00, wb_sel = 00.
  - lw: regdst = 00, wb_sel = 01.
  - Then go to FETCH.
- Timeout counter:
  - Clears on entry to FETCH or MEM and on mem_ack.
  - Increments each cycle mem_req is high without mem_ack.
  - When it reaches TIMEOUT (TIMEOUT > 0): pulse bus_err, go to HALT.
  - mem_ack on the same cycle the limit is reached wins: no error.
- HALT: halted = 1, all other outputs 0. Only rst exits HALT.
- Latency with mem_ack in the first cycle of each request:
  - j/jal: 2 cycles.
  - beq: 3 cycles.
  - R-type, I-type ALU, sw: 4 cycles.
  - lw: 5 cycles.
- Legal set:
  - opcode 00 with funct 21, 23, 00 or 02 (hex).
  - opcode 0d, 0f, 09, 23, 2b, 04, 02, 03 (hex).
  - Everything else is illegal.
- A mem_ack outside FETCH/MEM is ignored.
- rst asserted mid-request drops mem_req immediately (asynchronously).

Decomposition:
- Package mc_defs holds:
  - state encoding: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT;
  - opcode and funct constants;
  - alu_op, extop, pc_sel, regdst and wb_sel encodings.
- Sub-module mc_decode: combinational opcode/funct -> instruction class, legal flag, and EXEC/WB control fields. mc_ctrl holds the FSM and the timeout counter.

Test Plan:
- addu (op 00, funct 21), mem_ack in the first FETCH cycle -> states FETCH, DECODE, EXEC, WB; WB shows reg_we = 1, regdst = 01, wb_sel = 00; 4 cycles total.
- lw (op 23) with mem_ack delayed 3 cycles in MEM -> EXEC: extop = 11, alusrc = 1; mem_req held with iord = 1 for 3 cycles; WB: wb_sel = 01; 7 cycles total.
- beq with zero = 1, then again with zero = 0 -> pc_we = 1, pc_sel = 01 in EXEC only when zero = 1; 3 cycles each, back to FETCH.
- jal (op 03) -> DECODE: pc_we = 1, pc_sel = 10, reg_we = 1, regdst = 10, wb_sel = 10; next state FETCH.
- Illegal op 3f: with HALT_ON_ILLEGAL = 0, one illegal pulse then FETCH; with HALT_ON_ILLEGAL = 1, halted stays 1 until rst.
- TIMEOUT = 4, mem_ack never asserted in FETCH -> bus_err pulses on the 4th wait cycle, then HALT. rst asserted mid-FETCH -> mem_req drops the same cycle, IDLE, then FETCH.
